// File: rtl/vga_pkg.sv
// Shared VGA definitions: FSM state encoding, pixel bus width and colour constants.
package vga_pkg;

  localparam int unsigned RGB_W = 3;

  localparam logic [RGB_W-1:0] BLACK = 3'b000;
  localparam logic [RGB_W-1:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Auto-cycle successor: 1..7, wrapping to 1 so black is never shown.
  function automatic logic [RGB_W-1:0] next_cycle_color(input logic [RGB_W-1:0] c);
    if (c == WHITE) return 3'b001;
    return c + 3'd1;
  endfunction

endpackage

// File: rtl/vga_debounce.sv
// Two-flop synchroniser plus saturating stability counter for a bus of switches.
module vga_debounce #(
  parameter int unsigned W          = 3,
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned CNT_W      = 19
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sw,
  output logic [W-1:0] sw_stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [W-1:0]     sync1;
  logic [W-1:0]     sw_s;
  logic [W-1:0]     sw_cand;
  logic [CNT_W-1:0] cnt;

  // A candidate must stay unchanged for DEB_CYCLES samples before it is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      sw_s      <= '0;
      sw_cand   <= '0;
      sw_stable <= '0;
      cnt       <= '0;
    end else begin
      sync1 <= sw;
      sw_s  <= sync1;
      if (sw_s != sw_cand) begin
        sw_cand <= sw_s;
        cnt     <= '0;
      end else if (cnt == CNT_MAX) begin
        sw_stable <= sw_cand;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_color_sched.sv
// Frame-synchronous colour scheduler: debounced switch colour is committed only at frame_start.
// Optional auto-cycle mode when VGA_COLOR_SCHED_CYCLE_EN is defined.
module vga_color_sched
  import vga_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 500000,
  parameter int unsigned CNT_W        = 19,
  parameter int unsigned CYCLE_FRAMES = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             swt1,
  input  logic             swt2,
  input  logic             swt3,
  input  logic             frame_start,
  input  logic             video_on,
  output logic [RGB_W-1:0] rgb,
  output logic             pending,
  output logic             commit
);

  if ((64'd1 << CNT_W) <= 64'(DEB_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for DEB_CYCLES");
  end
  if (CYCLE_FRAMES < 1) begin : g_bad_cycle_frames
    $error("CYCLE_FRAMES must be at least 1");
  end

  logic [RGB_W-1:0] sw_stable;
  logic [RGB_W-1:0] color_reg;
  logic [RGB_W-1:0] color_d;
  logic             req_c;
  logic             step_c;
  logic             pending_d;
  logic             commit_d;
  state_t           state;
  state_t           state_next;

  vga_debounce #(
    .W          (RGB_W),
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .sw        ({swt1, swt2, swt3}),
    .sw_stable (sw_stable)
  );

`ifdef VGA_COLOR_SCHED_CYCLE_EN
  localparam int unsigned FRM_W = $clog2(CYCLE_FRAMES + 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(CYCLE_FRAMES - 1);

  logic [FRM_W-1:0] frm_cnt;

  // All-off switches hand the colour over to the frame counter.
  assign req_c  = (sw_stable != color_reg) && (sw_stable != BLACK);
  assign step_c = (sw_stable == BLACK) && frame_start && (frm_cnt == FRM_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frm_cnt <= '0;
    end else if (sw_stable != BLACK) begin
      frm_cnt <= '0;
    end else if (frame_start) begin
      frm_cnt <= (frm_cnt == FRM_LAST) ? '0 : frm_cnt + FRM_W'(1);
    end
  end
`else
  assign req_c  = (sw_stable != color_reg);
  assign step_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // A request seen in IDLE always waits for a later frame_start.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = req_c ? PEND : IDLE;
      PEND: begin
        if (!req_c)          state_next = IDLE;
        else if (frame_start) state_next = COMMIT;
        else                  state_next = PEND;
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    color_d   = color_reg;
    pending_d = (state_next == PEND);
    commit_d  = (state_next == COMMIT) || step_c;
    if ((state == PEND) && req_c && frame_start) begin
      color_d = sw_stable;
    end else if (step_c) begin
`ifdef VGA_COLOR_SCHED_CYCLE_EN
      color_d = next_cycle_color(color_reg);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      color_reg <= BLACK;
      pending   <= 1'b0;
      commit    <= 1'b0;
      rgb       <= BLACK;
    end else begin
      color_reg <= color_d;
      pending   <= pending_d;
      commit    <= commit_d;
      rgb       <= video_on ? color_reg : BLACK;
    end
  end

endmodule
